// File: rtl/decode_issue_ctrl_if.sv
// Decode/issue stage handshake bundle: instruction in, registered control bundle out.
// out_illegal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_ready;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [4:0]      out_alu_ctrl;
  logic            out_branch;
  logic            out_mem_to_reg;
  logic            out_mem_write;
  logic            out_alu_src;
  logic            out_alu_pc_src;
  logic            out_reg_write;
  logic            out_pc_jalr;
  logic            out_lui;
  logic            busy;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            out_illegal;
`endif

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_alu_ctrl, out_branch, out_mem_to_reg, out_mem_write, out_alu_src,
           out_alu_pc_src, out_reg_write, out_pc_jalr, out_lui, busy
`ifdef DECODE_ILLEGAL_TRAP_EN
         , out_illegal
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_alu_ctrl, out_branch, out_mem_to_reg, out_mem_write, out_alu_src,
           out_alu_pc_src, out_reg_write, out_pc_jalr, out_lui, busy
`ifdef DECODE_ILLEGAL_TRAP_EN
         , out_illegal
`endif
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// RV32IM registered decode/issue with MUL/DIV occupancy stall; DECODE_ILLEGAL_TRAP_EN adds out_illegal.
// Latency 1 cycle; bundle holds while out_ready=0, in_ready drops while busy, held or flushing.
module decode_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  decode_issue_ctrl_if.slave  io
);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_issue_ctrl: XLEN must be 32");
  end
  if (MUL_CYCLES < 1 || MUL_CYCLES > 63 || DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_cyc_chk
    $error("decode_issue_ctrl: MUL_CYCLES/DIV_CYCLES must be 1..63");
  end
  if ((1 << CNT_W) <= MAX_CYC) begin : g_cnt_chk
    $error("decode_issue_ctrl: CNT_W too narrow for occupancy");
  end

  localparam logic [4:0] ALUCTRL_NOP  = 5'd0,  ALUCTRL_ADD  = 5'd1,  ALUCTRL_SUB  = 5'd2;
  localparam logic [4:0] ALUCTRL_SLL  = 5'd3,  ALUCTRL_SLT  = 5'd4,  ALUCTRL_SLTU = 5'd5;
  localparam logic [4:0] ALUCTRL_XOR  = 5'd6,  ALUCTRL_SRL  = 5'd7,  ALUCTRL_SRA  = 5'd8;
  localparam logic [4:0] ALUCTRL_OR   = 5'd9,  ALUCTRL_AND  = 5'd10, ALUCTRL_MUL  = 5'd11;
  localparam logic [4:0] ALUCTRL_BEQ  = 5'd19, ALUCTRL_BNE  = 5'd20, ALUCTRL_BLT  = 5'd21;

  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111;

  localparam logic [CNT_W-1:0] MUL_OCC = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_OCC = CNT_W'(DIV_CYCLES - 1);

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       alu_pc_src;
    logic       reg_write;
    logic       pc_jalr;
    logic       lui;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  typedef enum logic { IDLE, BUSY } state_t;

  // funct3 -> ALU op shared by R and I-calc; alt selects SUB/SRA
  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_of_f3 = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'd1:    alu_of_f3 = ALUCTRL_SLL;
      3'd2:    alu_of_f3 = ALUCTRL_SLT;
      3'd3:    alu_of_f3 = ALUCTRL_SLTU;
      3'd4:    alu_of_f3 = ALUCTRL_XOR;
      3'd5:    alu_of_f3 = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'd6:    alu_of_f3 = ALUCTRL_OR;
      default: alu_of_f3 = ALUCTRL_AND;
    endcase
  endfunction

  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic             legal;
  logic [CNT_W-1:0] occ_d;
  ctrl_t            dec;

  assign opcode = io.in_instr[6:0];
  assign funct3 = io.in_instr[14:12];
  assign funct7 = io.in_instr[31:25];

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALUCTRL_NOP;
    legal        = 1'b1;
    occ_d        = '0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000001) begin
          dec.alu_ctrl = ALUCTRL_MUL + {2'b00, funct3};
          occ_d        = funct3[2] ? DIV_OCC : MUL_OCC;
        end else begin
          legal = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
          dec.alu_ctrl = alu_of_f3(funct3, funct7[5]);
        end
      end
      OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        legal = (funct3 != 3'd1 && funct3 != 3'd5) || (funct7 == 7'b0000000) ||
                (funct3 == 3'd5 && funct7 == 7'b0100000);
        dec.alu_ctrl = alu_of_f3(funct3, funct3 == 3'd5 && funct7[5]);
      end
      OP_LOAD: begin
        legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        dec.alu_ctrl   = ALUCTRL_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        legal = funct3 inside {3'd0, 3'd1, 3'd2};
        dec.alu_ctrl  = ALUCTRL_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        legal      = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.branch = 1'b1;
        if (funct3[2]) dec.alu_ctrl = ALUCTRL_BLT + {3'b000, funct3[1:0]};
        else           dec.alu_ctrl = funct3[0] ? ALUCTRL_BNE : ALUCTRL_BEQ;
      end
      OP_JAL: begin
        dec.alu_ctrl   = ALUCTRL_ADD;
        dec.branch     = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_pc_src = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_JALR: begin
        legal         = (funct3 == 3'd0);
        dec.alu_ctrl  = ALUCTRL_ADD;
        dec.alu_src   = 1'b1;
        dec.pc_jalr   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_ctrl   = ALUCTRL_ADD;
        dec.alu_src    = 1'b1;
        dec.alu_pc_src = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_LUI: begin
        dec.alu_ctrl  = ALUCTRL_ADD;
        dec.alu_src   = 1'b1;
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec          = '0;
      dec.alu_ctrl = ALUCTRL_NOP;
      occ_d        = '0;
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = !legal;
`endif
    if (io.in_instr[11:7] == 5'd0) dec.reg_write = 1'b0;
  end

  ctrl_t            bundle_q;
  logic             vld_q, busy_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       f3_q;
  logic [CNT_W-1:0] occ_q, cnt_q;
  state_t           state_q;
  logic             accept, xfer;

  assign io.in_ready = !busy_q && (!vld_q || io.out_ready) && !io.flush;
  assign accept      = io.in_valid && io.in_ready;
  assign xfer        = vld_q && io.out_ready && !io.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q             <= 1'b0;
      bundle_q          <= '0;
      bundle_q.alu_ctrl <= ALUCTRL_NOP;
      pc_q              <= '0;
      rd_q              <= '0;
      rs1_q             <= '0;
      rs2_q             <= '0;
      f3_q              <= '0;
      occ_q             <= '0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      bundle_q <= dec;
      pc_q     <= io.in_pc;
      rd_q     <= io.in_instr[11:7];
      rs1_q    <= io.in_instr[19:15];
      rs2_q    <= io.in_instr[24:20];
      f3_q     <= funct3;
      occ_q    <= occ_d;
    end else if (xfer || io.flush) begin
      vld_q <= 1'b0;
    end
  end

  // Occupancy is armed only by a real transfer; BUSY ignores further transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (xfer && occ_q != '0) begin
          state_q <= BUSY;
          cnt_q   <= occ_q;
          busy_q  <= 1'b1;
        end
        default: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io.out_valid      = vld_q;
  assign io.out_pc         = pc_q;
  assign io.out_rd         = rd_q;
  assign io.out_rs1        = rs1_q;
  assign io.out_rs2        = rs2_q;
  assign io.out_funct3     = f3_q;
  assign io.out_alu_ctrl   = bundle_q.alu_ctrl;
  assign io.out_branch     = bundle_q.branch;
  assign io.out_mem_to_reg = bundle_q.mem_to_reg;
  assign io.out_mem_write  = bundle_q.mem_write;
  assign io.out_alu_src    = bundle_q.alu_src;
  assign io.out_alu_pc_src = bundle_q.alu_pc_src;
  assign io.out_reg_write  = bundle_q.reg_write;
  assign io.out_pc_jalr    = bundle_q.pc_jalr;
  assign io.out_lui        = bundle_q.lui;
  assign io.busy           = busy_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign io.out_illegal    = bundle_q.illegal;
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed steps then random traffic against a mask/match instruction table model.
module tb_decode_issue_ctrl;
  localparam int MUL_C = 1;
  localparam int DIV_C = 4;

  localparam logic [4:0] A_NOP = 5'd0,  A_ADD = 5'd1,  A_SUB = 5'd2,  A_SLL = 5'd3,  A_SLT = 5'd4;
  localparam logic [4:0] A_SLTU = 5'd5, A_XOR = 5'd6,  A_SRL = 5'd7,  A_SRA = 5'd8,  A_OR = 5'd9;
  localparam logic [4:0] A_AND = 5'd10, A_MUL = 5'd11, A_MULH = 5'd12, A_MULHSU = 5'd13;
  localparam logic [4:0] A_MULHU = 5'd14, A_DIV = 5'd15, A_DIVU = 5'd16, A_REM = 5'd17, A_REMU = 5'd18;
  localparam logic [4:0] A_BEQ = 5'd19, A_BNE = 5'd20, A_BLT = 5'd21, A_BGE = 5'd22;
  localparam logic [4:0] A_BLTU = 5'd23, A_BGEU = 5'd24;

  // flag order: branch, mem_to_reg, mem_write, alu_src, alu_pc_src, reg_write, pc_jalr, lui
  localparam logic [7:0] F_BR = 8'h80, F_M2R = 8'h40, F_MW = 8'h20, F_SRC = 8'h10;
  localparam logic [7:0] F_PCS = 8'h08, F_RW = 8'h04, F_JR = 8'h02, F_LUI = 8'h01;

  localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F, MO = 32'h0000007F;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  alu;
    logic [7:0]  fl;
    int          occ;
  } op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [4:0]  alu;
    logic [7:0]  fl;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(32)) io ();
  decode_issue_ctrl #(.XLEN(32), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  op_t  ops[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_vld;
  int   m_rem, m_occ;
  exp_t m_b, reset_b;

  task automatic add_op(input logic [31:0] mask, match, input logic [4:0] alu,
                        input logic [7:0] fl, input int occ);
    op_t o;
    o.mask = mask; o.match = match; o.alu = alu; o.fl = fl; o.occ = occ;
    ops.push_back(o);
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins, pc, output int occ);
    exp_t e;
    bit   found = 1'b0;
    e = '0;
    e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
    e.alu = A_NOP; e.ill = 1'b1; occ = 0;
    for (int i = 0; i < ops.size(); i++) begin
      if (!found && (ins & ops[i].mask) == ops[i].match) begin
        found = 1'b1; e.alu = ops[i].alu; e.fl = ops[i].fl; e.ill = 1'b0; occ = ops[i].occ;
      end
    end
    if (e.rd == 5'd0) e.fl = e.fl & ~F_RW;
`ifndef DECODE_ILLEGAL_TRAP_EN
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, v, input logic [31:0] ins, pc, input bit ordy, fl);
    exp_t obs;
    bit   exp_rdy, acc, xfer;
    int   occ;
    @(negedge clk);
    rst = r; io.in_valid = v; io.in_instr = ins; io.in_pc = pc; io.out_ready = ordy; io.flush = fl;
    #1;
    exp_rdy = (m_rem == 0) && (!m_vld || ordy) && !fl;
    obs.pc = io.out_pc; obs.rd = io.out_rd; obs.rs1 = io.out_rs1; obs.rs2 = io.out_rs2;
    obs.f3 = io.out_funct3; obs.alu = io.out_alu_ctrl;
    obs.fl = {io.out_branch, io.out_mem_to_reg, io.out_mem_write, io.out_alu_src,
              io.out_alu_pc_src, io.out_reg_write, io.out_pc_jalr, io.out_lui};
`ifdef DECODE_ILLEGAL_TRAP_EN
    obs.ill = io.out_illegal;
`else
    obs.ill = 1'b0;
`endif
    chk("in_ready", 64'(io.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(io.out_valid), 64'(m_vld));
    chk("busy", 64'(io.busy), 64'(m_rem != 0));
    chk("bundle", obs, m_b);
    if (r) begin
      m_vld = 1'b0; m_rem = 0; m_occ = 0; m_b = reset_b;
    end else begin
      acc  = v && exp_rdy;
      xfer = m_vld && ordy && !fl;
      if (m_rem > 0) m_rem--;
      else if (xfer && m_occ > 1) m_rem = m_occ - 1;
      if (acc) begin
        m_b = ref_dec(ins, pc, occ); m_occ = occ; m_vld = 1'b1;
      end else if (xfer || fl) m_vld = 1'b0;
    end
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093, I_ADD = 32'h002081B3, I_LUI = 32'h123450B7;
  localparam logic [31:0] I_LUI0 = 32'h12345037, I_DIV = 32'h0220C1B3, I_MUL = 32'h022081B3;

  int          nb, sel, k;
  logic [31:0] w;

  initial begin
    add_op(MR, 32'h00000033, A_ADD, F_RW, 0);  add_op(MR, 32'h40000033, A_SUB, F_RW, 0);
    add_op(MR, 32'h00001033, A_SLL, F_RW, 0);  add_op(MR, 32'h00002033, A_SLT, F_RW, 0);
    add_op(MR, 32'h00003033, A_SLTU, F_RW, 0); add_op(MR, 32'h00004033, A_XOR, F_RW, 0);
    add_op(MR, 32'h00005033, A_SRL, F_RW, 0);  add_op(MR, 32'h40005033, A_SRA, F_RW, 0);
    add_op(MR, 32'h00006033, A_OR, F_RW, 0);   add_op(MR, 32'h00007033, A_AND, F_RW, 0);
    add_op(MR, 32'h02000033, A_MUL, F_RW, MUL_C);   add_op(MR, 32'h02001033, A_MULH, F_RW, MUL_C);
    add_op(MR, 32'h02002033, A_MULHSU, F_RW, MUL_C); add_op(MR, 32'h02003033, A_MULHU, F_RW, MUL_C);
    add_op(MR, 32'h02004033, A_DIV, F_RW, DIV_C);   add_op(MR, 32'h02005033, A_DIVU, F_RW, DIV_C);
    add_op(MR, 32'h02006033, A_REM, F_RW, DIV_C);   add_op(MR, 32'h02007033, A_REMU, F_RW, DIV_C);
    add_op(MI, 32'h00000013, A_ADD, F_SRC | F_RW, 0);  add_op(MI, 32'h00002013, A_SLT, F_SRC | F_RW, 0);
    add_op(MI, 32'h00003013, A_SLTU, F_SRC | F_RW, 0); add_op(MI, 32'h00004013, A_XOR, F_SRC | F_RW, 0);
    add_op(MI, 32'h00006013, A_OR, F_SRC | F_RW, 0);   add_op(MI, 32'h00007013, A_AND, F_SRC | F_RW, 0);
    add_op(MR, 32'h00001013, A_SLL, F_SRC | F_RW, 0);  add_op(MR, 32'h00005013, A_SRL, F_SRC | F_RW, 0);
    add_op(MR, 32'h40005013, A_SRA, F_SRC | F_RW, 0);
    foreach (ops[i]) if (0) ;
    for (int f = 0; f < 6; f++) begin
      if (f != 3) add_op(MI, 32'h00000003 | (32'(f) << 12), A_ADD, F_SRC | F_M2R | F_RW, 0);
    end
    for (int f = 0; f < 3; f++) add_op(MI, 32'h00000023 | (32'(f) << 12), A_ADD, F_SRC | F_MW, 0);
    add_op(MI, 32'h00000063, A_BEQ, F_BR, 0);  add_op(MI, 32'h00001063, A_BNE, F_BR, 0);
    add_op(MI, 32'h00004063, A_BLT, F_BR, 0);  add_op(MI, 32'h00005063, A_BGE, F_BR, 0);
    add_op(MI, 32'h00006063, A_BLTU, F_BR, 0); add_op(MI, 32'h00007063, A_BGEU, F_BR, 0);
    add_op(MO, 32'h0000006F, A_ADD, F_BR | F_SRC | F_PCS | F_RW, 0);
    add_op(MI, 32'h00000067, A_ADD, F_SRC | F_JR | F_RW, 0);
    add_op(MO, 32'h00000017, A_ADD, F_SRC | F_PCS | F_RW, 0);
    add_op(MO, 32'h00000037, A_ADD, F_SRC | F_LUI | F_RW, 0);

    reset_b = '0; reset_b.alu = A_NOP;
    m_b = reset_b; m_vld = 1'b0; m_rem = 0; m_occ = 0;
    rst = 1'b1; io.in_valid = 1'b1; io.in_instr = I_ADDI; io.in_pc = '0;
    io.out_ready = 1'b1; io.flush = 1'b0;
    @(posedge clk);

    // reset held with in_valid high, then idle
    step(1, 1, I_ADDI, 32'h0, 1, 0);
    step(1, 1, I_ADDI, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);

    // addi then back-to-back adds
    step(0, 1, I_ADDI, 32'h100, 1, 0);
    step(0, 1, I_ADD, 32'h104, 1, 0);
    chk("addi_alu", 64'(io.out_alu_ctrl), 64'(A_ADD));
    chk("addi_rd", 64'(io.out_rd), 64'd1);
    for (int i = 0; i < 4; i++) step(0, 1, I_ADD, 32'h108 + 32'(4 * i), 1, 0);

    // lui, then lui to x0
    step(0, 1, I_LUI, 32'h200, 1, 0);
    step(0, 1, I_LUI0, 32'h204, 1, 0);
    chk("lui_flag", 64'(io.out_lui), 64'd1);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("lui_x0_rw", 64'(io.out_reg_write), 64'd0);

    // div occupancy
    step(0, 1, I_DIV, 32'h300, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    nb = 0;
    repeat (6) begin step(0, 1, I_ADD, 32'h304, 1, 0); nb += int'(io.busy); end
    chk("div_busy_cycles", 64'(nb), 64'(DIV_C - 1));

    // single-cycle mul never stalls
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 1, I_MUL, 32'h400, 1, 0);
    nb = 0;
    repeat (4) begin step(0, 0, 32'h0, 32'h0, 1, 0); nb += int'(io.busy); end
    chk("mul_busy_cycles", 64'(nb), 64'd0);

    // hold under backpressure
    step(0, 1, I_ADD, 32'h500, 1, 0);
    repeat (5) step(0, 1, I_LUI, 32'h504, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);

    // flush with ready beats transfer of a held div
    step(0, 1, I_DIV, 32'h600, 0, 0);
    step(0, 1, I_ADD, 32'h604, 1, 1);
    nb = 0;
    repeat (5) begin step(0, 0, 32'h0, 32'h0, 1, 0); nb += int'(io.busy); end
    chk("flush_no_busy", 64'(nb), 64'd0);

    // reset in the middle of occupancy
    step(0, 1, I_DIV, 32'h700, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(1, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("rst_busy_clear", 64'(io.busy), 64'd0);

    // all-ones word decodes as illegal
    step(0, 1, 32'hFFFFFFFF, 32'h800, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("ill_alu", 64'(io.out_alu_ctrl), 64'(A_NOP));
    chk("ill_rw_mw", 64'({io.out_reg_write, io.out_mem_write}), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", 64'(io.out_illegal), 64'd1);
`endif

    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50) begin
        k = int'($urandom_range(0, ops.size() - 1));
        w = ($urandom & ~ops[k].mask) | ops[k].match;
      end else if (sel < 75) w = 32'h02000033 | ($urandom & 32'h01FFFF80);
      else w = $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, w, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
